// File: rtl/serial_comparator.sv
// Bit-serial, MSB-first unsigned magnitude comparator with registered eq/gt/lt flags.
// Build option SERIAL_COMPARATOR_EARLY_EXIT_EN: finish on the first differing bit.

module serial_comparator_slice (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic a_gt
);
    assign diff = a ^ b;
    assign a_gt = a & ~b;
endmodule

module serial_comparator #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         AyB,
    output logic         AmayB,
    output logic         AmenB
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [N-1:0]  shA, shB;
    logic [CW-1:0] cnt;
    logic          decided, gt;
    logic          diff, a_gt, hit, dec_n, gt_n;

    serial_comparator_slice u_slice (
        .a    (shA[N-1]),
        .b    (shB[N-1]),
        .diff (diff),
        .a_gt (a_gt)
    );

    // First difference seen this cycle; later differences never override it.
    assign hit   = ~decided & diff;
    assign dec_n = decided | diff;
    assign gt_n  = decided ? gt : a_gt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = RUN;
            RUN: begin
                if (cnt == CW'(1)) state_n = DONE;
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
                if (hit) state_n = DONE;
`endif
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shA     <= '0;
            shB     <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            gt      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            AyB     <= 1'b0;
            AmayB   <= 1'b0;
            AmenB   <= 1'b0;
        end else begin
            busy <= (state_n != IDLE);
            done <= (state_n == DONE);
            case (state)
                IDLE: if (start) begin
                    shA     <= A;
                    shB     <= B;
                    cnt     <= CW'(N);
                    decided <= 1'b0;
                end
                RUN: begin
                    shA <= shA << 1;
                    shB <= shB << 1;
                    cnt <= cnt - CW'(1);
                    if (hit) begin
                        decided <= 1'b1;
                        gt      <= a_gt;
                    end
                    // Flags use this cycle's bit too, so an LSB-only difference lands.
                    if (state_n == DONE) begin
                        AyB   <= ~dec_n;
                        AmayB <= dec_n & gt_n;
                        AmenB <= dec_n & ~gt_n;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: N=8 vector table, corner sequences, and an N=4 exhaustive sweep.
module tb_serial_comparator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       st8 = 1'b0, st4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [3:0] a4 = '0, b4 = '0;
    logic busy8, done8, eq8, gt8, lt8;
    logic busy4, done4, eq4, gt4, lt4;

    serial_comparator #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .AyB(eq8), .AmayB(gt8), .AmenB(lt8)
    );
    serial_comparator #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(st4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .AyB(eq4), .AmayB(gt4), .AmenB(lt4)
    );

`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        logic [7:0] a, b;
        logic       eq, gt, lt;
        int         lat_fix, lat_ee;
    } vec_t;

    typedef struct {
        logic eq, gt, lt;
        int   lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[10];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [7:0] a, input logic [7:0] b, input int n);
        if (!EE) return n + 1;
        for (int i = n - 1; i >= 0; i--)
            if (a[i] != b[i]) return (n - i) + 1;
        return n + 1;
    endfunction

    // Called just after a rising edge with the selected DUT idle.
    task automatic op(input bit s4, input logic [7:0] a, input logic [7:0] b,
                      input logic eq, input logic gt, input logic lt,
                      input int lat, input string nm);
        exp_t e;
        int   n;
        bit   bz_ok;
        if (s4) begin a4 = a[3:0]; b4 = b[3:0]; st4 = 1'b1; end
        else    begin a8 = a;      b8 = b;      st8 = 1'b1; end
        e.eq = eq; e.gt = gt; e.lt = lt; e.lat = lat;
        sb.push_back(e);
        @(posedge clk); #1;
        st4 = 1'b0; st8 = 1'b0;
        n = 1; bz_ok = 1'b1;
        while (!(s4 ? done4 : done8) && n < 40) begin
            if (!(s4 ? busy4 : busy8)) bz_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        chk({nm, "/done"}, 32'(s4 ? done4 : done8), 32'd1);
        chk({nm, "/lat"}, 32'(n), 32'(e.lat));
        chk({nm, "/busy_run"}, 32'(bz_ok), 32'd1);
        chk({nm, "/busy_done"}, 32'(s4 ? busy4 : busy8), 32'd1);
        chk({nm, "/flags"}, s4 ? 32'({eq4, gt4, lt4}) : 32'({eq8, gt8, lt8}),
            32'({e.eq, e.gt, e.lt}));
        @(posedge clk); #1;
        chk({nm, "/done_pulse"}, 32'(s4 ? done4 : done8), 32'd0);
        chk({nm, "/idle"}, 32'(s4 ? busy4 : busy8), 32'd0);
    endtask

    initial begin
        int nd, nxt, per, n, off, idx;
        bit seen;
        tbl[0] = '{8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 9, 9};
        tbl[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 9, 2};
        tbl[2] = '{8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 9, 8};
        tbl[3] = '{8'hFE, 8'hFF, 1'b0, 1'b0, 1'b1, 9, 9};
        tbl[4] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9, 9};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 9, 9};
        tbl[6] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 9, 2};
        tbl[7] = '{8'h7F, 8'h80, 1'b0, 1'b0, 1'b1, 9, 2};
        tbl[8] = '{8'hC3, 8'hC7, 1'b0, 1'b0, 1'b1, 9, 7};
        tbl[9] = '{8'h0F, 8'h0E, 1'b0, 1'b1, 1'b0, 9, 9};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset/dut8", 32'({busy8, done8, eq8, gt8, lt8}), 32'd0);
        chk("reset/dut4", 32'({busy4, done4, eq4, gt4, lt4}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            op(1'b0, tbl[i].a, tbl[i].b, tbl[i].eq, tbl[i].gt, tbl[i].lt,
               EE ? tbl[i].lat_ee : tbl[i].lat_fix, $sformatf("tbl%0d", i));

        // Flags hold through idle and through a new start
        repeat (3) begin @(posedge clk); #1; end
        chk("hold/idle", 32'({eq8, gt8, lt8}), 32'b010);
        a8 = 8'h00; b8 = 8'h00; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        @(posedge clk); #1;
        chk("hold/run_busy", 32'(busy8), 32'd1);
        chk("hold/run_flags", 32'({eq8, gt8, lt8}), 32'b010);
        n = 0;
        while (!done8 && n < 20) begin @(posedge clk); #1; n++; end
        chk("hold/new_result", 32'({done8, eq8, gt8, lt8}), 32'b1100);
        @(posedge clk); #1;

        // start held high; operands scrambled whenever busy
        per = EE ? 8 : 10;
        nxt = EE ? 7 : 9;
        nd  = 0;
        a8 = 8'd3; b8 = 8'd5; st8 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (done8) begin
                nd++;
                chk("cont/done_cycle", 32'(c), 32'(nxt));
                chk("cont/flags", 32'({eq8, gt8, lt8}), 32'b001);
                nxt += per;
            end else if (nd > 0) begin
                chk("cont/hold", 32'({eq8, gt8, lt8}), 32'b001);
            end
            if (busy8) begin a8 = 8'($urandom); b8 = 8'($urandom); end
            else       begin a8 = 8'd3;         b8 = 8'd5;         end
        end
        st8 = 1'b0;
        chk("cont/count", 32'(nd), 32'd3);
        n = 0;
        while (busy8 && n < 20) begin @(posedge clk); #1; n++; end
        chk("cont/drain", 32'(busy8), 32'd0);

        // Asynchronous reset in the 4th RUN cycle
        a8 = 8'd3; b8 = 8'd5; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort/busy_before", 32'(busy8), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort/async", 32'({busy8, done8, eq8, gt8, lt8}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (done8 || busy8) seen = 1'b1; end
        chk("abort/no_done", 32'(seen), 32'd0);
        op(1'b0, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, EE ? 2 : 9, "abort/next");

        // Reset beats a simultaneous start
        rst = 1'b1; st8 = 1'b1; a8 = 8'h01; b8 = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0; st8 = 1'b0;
        @(posedge clk); #1;
        chk("rst_start/busy", 32'({busy8, done8}), 32'd0);

        // N=4: all 256 pairs in a scrambled order
        off = int'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a, b;
            idx = (i * 37 + off) & 255;
            a = {4'h0, 4'(idx >> 4)};
            b = {4'h0, 4'(idx)};
            op(1'b1, a, b, a == b, a > b, a < b, lat_of(a, b, 4), "sweep");
        end

        chk("scoreboard/empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
